// File: rtl/fetch_queue_param_if.sv
// Handshake and bus signals between the fetch queue and the PC controller, decoder and memory dispatcher.
interface fetch_queue_param_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned CNT_W  = 4
);
   logic              in_rdy;
   logic              in_stall;
   logic              in_flush_enable;
   logic              in_icache_inval;
   logic              in_fetcher_enable;
   logic [ADDR_W-1:0] in_pc;
   logic              in_predict;
   logic              out_pc_fetch_full;
   logic [CNT_W-1:0]  out_count;
   logic              out_pc_last_enable;
   logic [ADDR_W-1:0] out_pc_last_pc;
   logic [INST_W-1:0] out_pc_last_inst;
   logic              out_decoder_decode_enable;
   logic [INST_W-1:0] out_decoder_pc_inst;
   logic [ADDR_W-1:0] out_decoder_pc_addr;
   logic              out_decoder_pc_pre;
   logic              out_dispatch_pc_requesting;
   logic [ADDR_W-1:0] out_dispatch_pc_addr;
   logic [INST_W-1:0] in_dispatch_pc_inst;
   logic              in_pc_req_enable;
   logic              in_pc_data_enable;

   modport master (
      output in_rdy, in_stall, in_flush_enable, in_icache_inval, in_fetcher_enable,
             in_pc, in_predict, in_dispatch_pc_inst, in_pc_req_enable, in_pc_data_enable,
      input  out_pc_fetch_full, out_count, out_pc_last_enable, out_pc_last_pc, out_pc_last_inst,
             out_decoder_decode_enable, out_decoder_pc_inst, out_decoder_pc_addr,
             out_decoder_pc_pre, out_dispatch_pc_requesting, out_dispatch_pc_addr
   );

   modport slave (
      input  in_rdy, in_stall, in_flush_enable, in_icache_inval, in_fetcher_enable,
             in_pc, in_predict, in_dispatch_pc_inst, in_pc_req_enable, in_pc_data_enable,
      output out_pc_fetch_full, out_count, out_pc_last_enable, out_pc_last_pc, out_pc_last_inst,
             out_decoder_decode_enable, out_decoder_pc_inst, out_decoder_pc_addr,
             out_decoder_pc_pre, out_dispatch_pc_requesting, out_dispatch_pc_addr
   );
endinterface

// File: rtl/fetch_queue_param.sv
// Parametrised instruction fetch queue with a direct-mapped icache and flush-safe memory fill.
module fetch_queue_param #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned INST_W      = 32,
   parameter int unsigned OFFSET_BITS = 2,
   parameter int unsigned INDEX_BITS  = 8,
   parameter int unsigned TAG_BITS    = 10,
   parameter int unsigned FULL_MARGIN = 1
) (
   input logic           in_clk,
   input logic           in_rst,
   fetch_queue_param_if.slave bus
);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned LINES   = 1 << INDEX_BITS;
   localparam int unsigned TAG_LSB = OFFSET_BITS + INDEX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t state_q, state_n;

   logic [PTR_W-1:0]  head_q, fill_q, tail_q;
   logic [CNT_W-1:0]  count_q, ready_q, pending;

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic              pre_q  [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [INST_W-1:0]   data_q [LINES];

   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  hit, flush, enq, deq, do_fill, do_req, cache_wr;

   logic              last_en_q, dec_en_q, dec_pre_q, req_q;
   logic [ADDR_W-1:0] last_pc_q, dec_addr_q, req_addr_q;
   logic [INST_W-1:0] last_inst_q, dec_inst_q;

   // Icache lookup for the entry waiting at the fill pointer
   assign fill_idx = pc_q[fill_q][TAG_LSB-1:OFFSET_BITS];
   assign fill_tag = pc_q[fill_q][TAG_LSB+TAG_BITS-1:TAG_LSB];
   assign hit      = valid_q[fill_idx] && (tag_q[fill_idx] == fill_tag);

   // Queue bookkeeping: ready = filled but not issued, pending = enqueued but not filled
   assign flush   = bus.in_flush_enable;
   assign pending = count_q - ready_q;
   assign enq     = bus.in_fetcher_enable && !flush && (count_q != CNT_W'(DEPTH));
   assign deq     = !bus.in_stall && !flush && (ready_q != '0);

   // Fill FSM next state and fill/request strobes
   always_comb begin
      state_n  = state_q;
      do_fill  = 1'b0;
      do_req   = 1'b0;
      cache_wr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!flush && (pending != '0)) begin
               if (hit) begin
                  do_fill = 1'b1;
               end else if (bus.in_pc_req_enable) begin
                  do_req  = 1'b1;
                  state_n = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.in_pc_data_enable) begin
               state_n = S_IDLE;
               if (!flush) begin
                  do_fill  = 1'b1;
                  cache_wr = 1'b1;
               end
            end else if (flush) begin
               state_n = S_DROP;
            end
         end
         S_DROP: begin
            if (bus.in_pc_data_enable) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Fill FSM state register
   always_ff @(posedge in_clk) begin
      if (in_rst)          state_q <= S_IDLE;
      else if (bus.in_rdy) state_q <= state_n;
   end

   // Pointers, counters and registered outputs
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         head_q      <= '0;
         fill_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ready_q     <= '0;
         last_en_q   <= 1'b0;
         last_pc_q   <= '0;
         last_inst_q <= '0;
         dec_en_q    <= 1'b0;
         dec_inst_q  <= '0;
         dec_addr_q  <= '0;
         dec_pre_q   <= 1'b0;
         req_q       <= 1'b0;
         req_addr_q  <= '0;
      end else if (bus.in_rdy) begin
         last_en_q <= 1'b0;
         dec_en_q  <= 1'b0;
         req_q     <= 1'b0;
         if (flush) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= '0;
         end else begin
            if (enq) tail_q <= tail_q + PTR_W'(1);
            if (do_fill) begin
               fill_q      <= fill_q + PTR_W'(1);
               last_en_q   <= 1'b1;
               last_pc_q   <= pc_q[fill_q];
               last_inst_q <= cache_wr ? bus.in_dispatch_pc_inst : data_q[fill_idx];
            end
            if (do_req) begin
               req_q      <= 1'b1;
               req_addr_q <= pc_q[fill_q];
            end
            if (deq) begin
               head_q     <= head_q + PTR_W'(1);
               dec_en_q   <= 1'b1;
               dec_inst_q <= inst_q[head_q];
               dec_addr_q <= pc_q[head_q];
               dec_pre_q  <= pre_q[head_q];
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
            ready_q <= ready_q + CNT_W'(do_fill) - CNT_W'(deq);
         end
      end
   end

   // Queue entry storage (no reset needed: entries are only read once written)
   always_ff @(posedge in_clk) begin
      if (bus.in_rdy) begin
         if (enq) begin
            pc_q[tail_q]  <= bus.in_pc;
            pre_q[tail_q] <= bus.in_predict;
         end
         if (do_fill) inst_q[fill_q] <= cache_wr ? bus.in_dispatch_pc_inst : data_q[fill_idx];
      end
   end

   // Icache tag/data arrays, written on a memory fill
   always_ff @(posedge in_clk) begin
      if (bus.in_rdy && cache_wr) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.in_dispatch_pc_inst;
      end
   end

   // Icache valid bits; invalidate beats a same-cycle fill
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         valid_q <= '0;
      end else if (bus.in_rdy) begin
         if (bus.in_icache_inval) valid_q <= '0;
         else if (cache_wr)       valid_q[fill_idx] <= 1'b1;
      end
   end

   assign bus.out_pc_fetch_full          = (count_q >= CNT_W'(DEPTH - FULL_MARGIN));
   assign bus.out_count                  = count_q;
   assign bus.out_pc_last_enable         = last_en_q;
   assign bus.out_pc_last_pc             = last_pc_q;
   assign bus.out_pc_last_inst           = last_inst_q;
   assign bus.out_decoder_decode_enable  = dec_en_q;
   assign bus.out_decoder_pc_inst        = dec_inst_q;
   assign bus.out_decoder_pc_addr        = dec_addr_q;
   assign bus.out_decoder_pc_pre         = dec_pre_q;
   assign bus.out_dispatch_pc_requesting = req_q;
   assign bus.out_dispatch_pc_addr       = req_addr_q;
endmodule

// File: tb/tb_fetch_queue_param.sv
// Directed bench for fetch_queue_param: issue scoreboard plus direct checks of fill, request and count.
module tb_fetch_queue_param;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pre;
   } exp_t;

   logic in_clk = 1'b0;
   logic in_rst = 1'b1;
   int   n_vec  = 0;
   int   n_err  = 0;
   exp_t exp_q[$];

   logic        auto_mem = 1'b0;
   logic        am_den   = 1'b0;
   logic [31:0] am_data  = '0;
   logic        man_den  = 1'b0;
   logic [31:0] man_data = '0;

   logic [31:0] inst_tab [8] = '{32'h00100113, 32'h00200193, 32'h00300213, 32'h00400293,
                                 32'h00500313, 32'h00600393, 32'h00700413, 32'h00800493};

   fetch_queue_param_if #(.ADDR_W(32), .INST_W(32), .CNT_W(4)) bus ();

   fetch_queue_param dut (
      .in_clk (in_clk),
      .in_rst (in_rst),
      .bus    (bus)
   );

   always #5 in_clk = ~in_clk;

   assign bus.in_pc_data_enable   = auto_mem ? am_den  : man_den;
   assign bus.in_dispatch_pc_inst = auto_mem ? am_data : man_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] pc, input logic pred);
      bus.in_fetcher_enable = 1'b1;
      bus.in_pc             = pc;
      bus.in_predict        = pred;
      tick();
      bus.in_fetcher_enable = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pre);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      e.pre  = pre;
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'h3000;
      if (off < 32'h20) return inst_tab[off[4:2]];
      return 32'h00000013;
   endfunction

   // Memory model: answers each request one cycle after it is seen
   always @(posedge in_clk) begin
      #1;
      if (auto_mem && bus.out_dispatch_pc_requesting) begin
         am_den  = 1'b1;
         am_data = mem_data(bus.out_dispatch_pc_addr);
      end else begin
         am_den  = 1'b0;
      end
   end

   // Issue monitor: every new decode beat must match the oldest expected entry
   always @(posedge in_clk) begin
      logic rdy_s, rst_s;
      exp_t e;
      rdy_s = bus.in_rdy;
      rst_s = in_rst;
      #1;
      if (rdy_s === 1'b1 && rst_s === 1'b0 && bus.out_decoder_decode_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue at %0t",
                     bus.out_decoder_pc_addr, $time);
         end else begin
            e = exp_q.pop_front();
            check("issue_pc",   64'(bus.out_decoder_pc_addr), 64'(e.pc));
            check("issue_inst", 64'(bus.out_decoder_pc_inst), 64'(e.inst));
            check("issue_pre",  64'(bus.out_decoder_pc_pre),  64'(e.pre));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish before 100000ns");
      $fatal(1);
   end

   initial begin
      bus.in_rdy            = 1'b1;
      bus.in_stall          = 1'b0;
      bus.in_flush_enable   = 1'b0;
      bus.in_icache_inval   = 1'b0;
      bus.in_fetcher_enable = 1'b1;
      bus.in_pc             = 32'h1000;
      bus.in_predict        = 1'b1;
      bus.in_pc_req_enable  = 1'b1;

      // Reset, with an enqueue attempt that reset must override
      in_rst = 1'b1;
      repeat (3) tick();
      bus.in_fetcher_enable = 1'b0;
      in_rst = 1'b0;
      check("rst_count",   64'(bus.out_count), 64'd0);
      check("rst_full",    64'(bus.out_pc_fetch_full), 64'd0);
      check("rst_decode",  64'(bus.out_decoder_decode_enable), 64'd0);
      check("rst_req",     64'(bus.out_dispatch_pc_requesting), 64'd0);
      check("rst_last",    64'(bus.out_pc_last_enable), 64'd0);

      // Cold miss for 0x1000
      push(32'h1000, 32'h00A00093, 1'b1);
      enq(32'h1000, 1'b1);
      check("t1_count", 64'(bus.out_count), 64'd1);
      tick();
      check("t1_req",      64'(bus.out_dispatch_pc_requesting), 64'd1);
      check("t1_req_addr", 64'(bus.out_dispatch_pc_addr), 64'h1000);
      tick();
      check("t1_req_pulse", 64'(bus.out_dispatch_pc_requesting), 64'd0);
      tick();
      man_den  = 1'b1;
      man_data = 32'h00A00093;
      tick();
      man_den  = 1'b0;
      check("t1_last_en",   64'(bus.out_pc_last_enable), 64'd1);
      check("t1_last_pc",   64'(bus.out_pc_last_pc), 64'h1000);
      check("t1_last_inst", 64'(bus.out_pc_last_inst), 64'h00A00093);
      check("t1_no_dec_yet", 64'(bus.out_decoder_decode_enable), 64'd0);
      tick();
      check("t1_dec_en", 64'(bus.out_decoder_decode_enable), 64'd1);
      check("t1_count0", 64'(bus.out_count), 64'd0);

      // Flush, then 0x1000 again hits in the cache
      bus.in_flush_enable = 1'b1;
      tick();
      bus.in_flush_enable = 1'b0;
      check("t2_flush_count", 64'(bus.out_count), 64'd0);
      push(32'h1000, 32'h00A00093, 1'b0);
      enq(32'h1000, 1'b0);
      tick();
      check("t2_no_req",  64'(bus.out_dispatch_pc_requesting), 64'd0);
      check("t2_last_en", 64'(bus.out_pc_last_enable), 64'd1);
      check("t2_dec_n1",  64'(bus.out_decoder_decode_enable), 64'd0);
      tick();
      check("t2_dec_n2",  64'(bus.out_decoder_decode_enable), 64'd1);

      // Fill all 8 entries under stall, 9th enqueue dropped, then drain
      bus.in_stall = 1'b1;
      auto_mem     = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) push(32'h3000 + 32'(4 * i), inst_tab[i], 1'(i % 2));
         enq(32'h3000 + 32'(4 * i), 1'(i % 2));
         check("t3_count", 64'(bus.out_count), 64'((i + 1 > 8) ? 8 : i + 1));
         check("t3_full",  64'(bus.out_pc_fetch_full), 64'((i + 1 >= 7) ? 1 : 0));
      end
      repeat (24) tick();
      check("t3_count_hold", 64'(bus.out_count), 64'd8);
      bus.in_stall = 1'b0;
      repeat (8) tick();
      check("t3_drained", 64'(bus.out_count), 64'd0);
      tick();
      check("t3_idle_dec", 64'(bus.out_decoder_decode_enable), 64'd0);
      auto_mem = 1'b0;
      tick();

      // Flush while a miss is outstanding; the late response must be dropped
      enq(32'h4000, 1'b0);
      tick();
      check("t4_req",      64'(bus.out_dispatch_pc_requesting), 64'd1);
      check("t4_req_addr", 64'(bus.out_dispatch_pc_addr), 64'h4000);
      bus.in_flush_enable = 1'b1;
      tick();
      bus.in_flush_enable = 1'b0;
      check("t4_flush_count", 64'(bus.out_count), 64'd0);
      tick();
      man_den  = 1'b1;
      man_data = 32'hDEADBEEF;
      tick();
      man_den  = 1'b0;
      check("t4_drop_last", 64'(bus.out_pc_last_enable), 64'd0);
      tick();
      check("t4_drop_dec", 64'(bus.out_decoder_decode_enable), 64'd0);
      push(32'h4000, 32'h00400413, 1'b1);
      enq(32'h4000, 1'b1);
      tick();
      check("t4_new_req",  64'(bus.out_dispatch_pc_requesting), 64'd1);
      check("t4_new_addr", 64'(bus.out_dispatch_pc_addr), 64'h4000);
      man_den  = 1'b1;
      man_data = 32'h00400413;
      tick();
      man_den  = 1'b0;
      check("t4_last_inst", 64'(bus.out_pc_last_inst), 64'h00400413);
      tick();

      // Invalidate coinciding with the fill of 0x2000
      push(32'h2000, 32'h00200513, 1'b0);
      enq(32'h2000, 1'b0);
      tick();
      check("t5_req", 64'(bus.out_dispatch_pc_requesting), 64'd1);
      man_den  = 1'b1;
      man_data = 32'h00200513;
      bus.in_icache_inval = 1'b1;
      tick();
      man_den  = 1'b0;
      bus.in_icache_inval = 1'b0;
      check("t5_last_en", 64'(bus.out_pc_last_enable), 64'd1);
      tick();
      push(32'h2000, 32'h00200593, 1'b1);
      enq(32'h2000, 1'b1);
      tick();
      check("t5_miss_req",  64'(bus.out_dispatch_pc_requesting), 64'd1);
      check("t5_miss_addr", 64'(bus.out_dispatch_pc_addr), 64'h2000);
      man_den  = 1'b1;
      man_data = 32'h00200593;
      tick();
      man_den  = 1'b0;
      tick();
      push(32'h2000, 32'h00200593, 1'b0);
      enq(32'h2000, 1'b0);
      tick();
      check("t5_hit_noreq", 64'(bus.out_dispatch_pc_requesting), 64'd0);
      check("t5_hit_last",  64'(bus.out_pc_last_enable), 64'd1);
      tick();

      // Simultaneous enqueue and issue at count 3, then a frozen cycle
      bus.in_stall = 1'b1;
      push(32'h2000, 32'h00200593, 1'b0);
      enq(32'h2000, 1'b0);
      push(32'h2000, 32'h00200593, 1'b1);
      enq(32'h2000, 1'b1);
      push(32'h2000, 32'h00200593, 1'b0);
      enq(32'h2000, 1'b0);
      repeat (3) tick();
      check("t6_count3", 64'(bus.out_count), 64'd3);
      push(32'h2000, 32'h00200593, 1'b1);
      bus.in_stall = 1'b0;
      enq(32'h2000, 1'b1);
      check("t6_count_same", 64'(bus.out_count), 64'd3);
      check("t6_dec_en",     64'(bus.out_decoder_decode_enable), 64'd1);
      bus.in_rdy = 1'b0;
      repeat (2) tick();
      check("t6_frz_count", 64'(bus.out_count), 64'd3);
      check("t6_frz_dec",   64'(bus.out_decoder_decode_enable), 64'd1);
      check("t6_frz_pre",   64'(bus.out_decoder_pc_pre), 64'd0);
      bus.in_rdy = 1'b1;
      repeat (5) tick();
      check("t6_drained", 64'(bus.out_count), 64'd0);

      repeat (3) tick();
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
